addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit adder/subtractor.
// Accepts one operation at a time: IDLE -> EXEC -> RESP.
module adder_subtractor (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       mode,
    output logic [7:0] result,
    output logic       ovfl
);
    logic [7:0] w_bx;

    assign w_bx   = mode ? ~b : b;
    assign result = a + w_bx + {7'd0, mode};
    // Overflow when effective operands agree in sign but the result does not.
    assign ovfl   = (a[7] == w_bx[7]) && (result[7] != a[7]);
endmodule

module addsub_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_mode,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_mode,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic       rsp_ovfl,
    output logic [7:0] ops_done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_last;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_mode;
    logic       r_id;
    logic [7:0] r_result;
    logic       r_ovfl;
    logic [7:0] r_ops;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_accept;
    logic [7:0] w_res;
    logic       w_ovfl;

    // Round-robin: a lone requester wins; on contention the one not last served.
    assign w_gnt0   = req0_valid && (!req1_valid || r_last);
    assign w_gnt1   = req1_valid && (!req0_valid || !r_last);
    assign w_accept = (r_state == S_IDLE) && (w_gnt0 || w_gnt1);

    adder_subtractor u_alu (
        .a      (r_a),
        .b      (r_b),
        .mode   (r_mode),
        .result (w_res),
        .ovfl   (w_ovfl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_gnt0 || w_gnt1) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                req0_ready = rst_n && w_gnt0;
                req1_ready = rst_n && w_gnt1;
            end
            S_RESP:  rsp_valid = rst_n;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_mode   <= 1'b0;
            r_id     <= 1'b0;
            r_result <= 8'h00;
            r_ovfl   <= 1'b0;
            r_ops    <= 8'h00;
        end else begin
            if (w_accept) begin
                r_a    <= w_gnt1 ? req1_a : req0_a;
                r_b    <= w_gnt1 ? req1_b : req0_b;
                r_mode <= w_gnt1 ? req1_mode : req0_mode;
                r_id   <= w_gnt1;
                r_last <= w_gnt1;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_res;
                r_ovfl   <= w_ovfl;
            end
            if (r_state == S_RESP && rsp_ready) begin
                r_ops <= r_ops + 8'd1;
            end
        end
    end

    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_ovfl   = r_ovfl;
    assign ops_done   = r_ops;
endmodule
